nbr_eval_ctrl: RTL

- Challenge/response initiator for the 32-bit bistable-ring PUF macro.
- Accepts a challenge over a valid/ready request port and drives it onto the PUF challenge bus.
- Sequences PUF reset and release, waits a settle window, then samples the ring output through a 2-flop synchronizer. Repeats NEVAL times and majority-votes.
- Returns the response bit plus the ones count on a valid/ready response port. Sits between the PUF macro and the scan/host interface.

---
 rtl/nbr_eval_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/nbr_eval_ctrl.sv
// Challenge/response initiator for the bistable-ring PUF macro.
// Runs NEVAL reset/settle/sample evaluations per challenge and majority-votes the samples.
module nbr_eval_ctrl #(
  parameter int unsigned CW         = 32,
  parameter int unsigned RST_CYC    = 16,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned NEVAL      = 7,
  parameter int unsigned NW         = $clog2(NEVAL + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [CW-1:0] REQ_CHAL,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic          RSP_BIT,
  output logic [NW-1:0] RSP_ONES,
  output logic [CW-1:0] PUF_C,
  output logic          PUF_RESET,
  input  logic          PUF_OUT
);

  localparam int unsigned CMAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int unsigned CNTW = $clog2(CMAX + 1);

  typedef enum logic [1:0] {StIdle, StArm, StSettle, StDone} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cyc_q, cyc_d;
  logic [NW-1:0]   eval_q, eval_d;
  logic [NW-1:0]   ones_q, ones_d;
  logic [CW-1:0]   chal_q, chal_d;
  logic            bit_q, bit_d;
  logic [1:0]      sync_q;
  logic            puf_reset_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    eval_d  = eval_q;
    ones_d  = ones_q;
    chal_d  = chal_q;
    bit_d   = bit_q;
    case (state_q)
      StIdle: begin
        if (REQ_VALID) begin
          chal_d  = REQ_CHAL;
          ones_d  = '0;
          eval_d  = '0;
          cyc_d   = '0;
          state_d = StArm;
        end
      end
      StArm: begin
        if (cyc_q == CNTW'(RST_CYC - 1)) begin
          cyc_d   = '0;
          state_d = StSettle;
        end else begin
          cyc_d = cyc_q + CNTW'(1);
        end
      end
      StSettle: begin
        if (cyc_q == CNTW'(SETTLE_CYC - 1)) begin
          cyc_d   = '0;
          // sync_q[1] holds PUF_OUT as it was two edges before this sample edge
          ones_d  = ones_q + NW'(sync_q[1]);
          eval_d  = eval_q + NW'(1);
          bit_d   = (ones_d > NW'(NEVAL / 2));
          state_d = (eval_q == NW'(NEVAL - 1)) ? StDone : StArm;
        end else begin
          cyc_d = cyc_q + CNTW'(1);
        end
      end
      StDone: begin
        if (RSP_READY) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      cyc_q       <= '0;
      eval_q      <= '0;
      ones_q      <= '0;
      chal_q      <= '0;
      bit_q       <= 1'b0;
      sync_q      <= 2'b00;
      puf_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      eval_q      <= eval_d;
      ones_q      <= ones_d;
      chal_q      <= chal_d;
      bit_q       <= bit_d;
      sync_q      <= {sync_q[0], PUF_OUT};
      // Registered so the ring reset never glitches on state decode
      puf_reset_q <= (state_d != StSettle);
    end
  end

  assign REQ_READY = (state_q == StIdle);
  assign RSP_VALID = (state_q == StDone);
  assign RSP_BIT   = bit_q;
  assign RSP_ONES  = ones_q;
  assign PUF_C     = chal_q;
  assign PUF_RESET = puf_reset_q;

endmodule
